// File: rtl/keypad_scanner_if.sv
// Keypad matrix lines plus the decoded move/select outputs handed to the game core.
// master = scanner side, slave = keypad/game side.
interface keypad_scanner_if;
  logic [3:0] col_n;
  logic [3:0] row_n;
  logic [8:0] move;
  logic       move_strobe;
  logic       select_n;
  logic       confirm_pulse;
  logic       multi_key;

  modport master (
    input  col_n,
    output row_n, move, move_strobe, select_n, confirm_pulse, multi_key
  );

  modport slave (
    output col_n,
    input  row_n, move, move_strobe, select_n, confirm_pulse, multi_key
  );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 keypad row strober with frame debounce; emits a one-hot move plus '#' select/confirm.
// KEYPAD_GHOST_REJECT_EN: multi-key frames become their own code instead of resolving to the lowest key.
module keypad_scanner #(
  parameter int CLK_HZ          = 50000000,
  parameter int SCAN_HZ         = 1000,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic             MAX10_CLK1_50,
  input  logic             rst,
  keypad_scanner_if.master kp
);

  localparam int ROW_CYCLES = CLK_HZ / SCAN_HZ;
  localparam int CW         = (ROW_CYCLES > 2) ? $clog2(ROW_CYCLES) : 2;

  if (ROW_CYCLES < 3) begin : g_bad_rate
    $error("keypad_scanner: CLK_HZ/SCAN_HZ must be at least 3");
  end
  if (DEBOUNCE_FRAMES < 1 || DEBOUNCE_FRAMES > 15) begin : g_bad_debounce
    $error("keypad_scanner: DEBOUNCE_FRAMES must be 1..15");
  end

  localparam logic [CW-1:0] CNT_LAST_DRIVE = CW'(ROW_CYCLES - 2);
  localparam logic [3:0]    DB_MAX         = 4'(DEBOUNCE_FRAMES);

  localparam logic [0:0] S_DRIVE  = 1'b0;
  localparam logic [0:0] S_SAMPLE = 1'b1;

  localparam logic [3:0] C_NONE  = 4'd0;
  localparam logic [3:0] C_DIG1  = 4'd1;
  localparam logic [3:0] C_DIG9  = 4'd9;
  localparam logic [3:0] C_STAR  = 4'd10;
  localparam logic [3:0] C_HASH  = 4'd11;
`ifdef KEYPAD_GHOST_REJECT_EN
  localparam logic [3:0] C_MULTI = 4'd12;
`endif

  // Digits 1-9, '*' and '#'; the '0' key and column 3 are ignored.
  localparam logic [15:0] LEGAL_KEYS = 16'h5777;

  logic [3:0]    r_col_s1, r_col_s2;
  logic [0:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_row;
  logic [15:0]   r_frame;
  logic          r_frame_done;

  logic [3:0]    r_prev_code, r_db_cnt, r_acc_code;
  logic [8:0]    r_move;
  logic          r_move_strobe, r_select_n, r_confirm, r_multi;

  logic [15:0]   w_closed;
  logic [3:0]    w_nkeys, w_first, w_first_code, w_code, w_db_next;
  logic          w_accept;

  always_ff @(posedge MAX10_CLK1_50) begin
    if (!rst) begin
      r_col_s1     <= 4'b1111;
      r_col_s2     <= 4'b1111;
      r_state      <= S_DRIVE;
      r_cnt        <= '0;
      r_row        <= 2'd0;
      r_frame      <= 16'hFFFF;
      r_frame_done <= 1'b0;
    end else begin
      r_col_s1     <= kp.col_n;
      r_col_s2     <= r_col_s1;
      r_frame_done <= 1'b0;
      case (r_state)
        S_DRIVE: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_LAST_DRIVE) r_state <= S_SAMPLE;
        end
        default: begin
          r_frame[{r_row, 2'b00} +: 4] <= r_col_s2;
          r_frame_done <= (r_row == 2'd3);
          r_row        <= r_row + 2'd1;
          r_cnt        <= '0;
          r_state      <= S_DRIVE;
        end
      endcase
    end
  end

  always_comb begin
    w_closed = ~r_frame & LEGAL_KEYS;
    w_nkeys  = 4'd0;
    w_first  = 4'd0;
    // Descending walk leaves the lowest row-major closed key in w_first.
    for (int i = 15; i >= 0; i--) begin
      if (w_closed[i]) begin
        w_nkeys = w_nkeys + 4'd1;
        w_first = 4'(i);
      end
    end

    if (w_first[3:2] != 2'd3)
      w_first_code = {2'b00, w_first[3:2]} * 4'd3 + {2'b00, w_first[1:0]} + 4'd1;
    else
      w_first_code = (w_first[1:0] == 2'd0) ? C_STAR : C_HASH;

    if (w_nkeys == 4'd0)
      w_code = C_NONE;
`ifdef KEYPAD_GHOST_REJECT_EN
    else if (w_nkeys > 4'd1)
      w_code = C_MULTI;
`endif
    else
      w_code = w_first_code;

    if (w_code != r_prev_code)   w_db_next = 4'd1;
    else if (r_db_cnt == DB_MAX) w_db_next = DB_MAX;
    else                         w_db_next = r_db_cnt + 4'd1;

    w_accept = (w_db_next == DB_MAX) && (w_code != r_acc_code);
  end

  always_ff @(posedge MAX10_CLK1_50) begin
    if (!rst) begin
      r_prev_code   <= C_NONE;
      r_db_cnt      <= 4'd0;
      r_acc_code    <= C_NONE;
      r_move        <= 9'd0;
      r_move_strobe <= 1'b0;
      r_select_n    <= 1'b1;
      r_confirm     <= 1'b0;
      r_multi       <= 1'b0;
    end else begin
      r_move_strobe <= 1'b0;
      r_confirm     <= 1'b0;
      if (r_frame_done) begin
        r_prev_code <= w_code;
        r_db_cnt    <= w_db_next;
        r_multi     <= (w_nkeys > 4'd1);
        if (w_accept) begin
          r_acc_code <= w_code;
          r_select_n <= 1'b1;
          if (w_code >= C_DIG1 && w_code <= C_DIG9) begin
            r_move        <= 9'd1 << (w_code - 4'd1);
            r_move_strobe <= 1'b1;
          end else if (w_code == C_STAR) begin
            r_move        <= 9'd0;
            r_move_strobe <= 1'b1;
          end else if (w_code == C_HASH) begin
            r_select_n <= 1'b0;
            r_confirm  <= 1'b1;
          end
        end
      end
    end
  end

  assign kp.row_n         = ~(4'b0001 << r_row);
  assign kp.move          = r_move;
  assign kp.move_strobe   = r_move_strobe;
  assign kp.select_n      = r_select_n;
  assign kp.confirm_pulse = r_confirm;
  assign kp.multi_key     = r_multi;

endmodule

// File: tb/tb_keypad_scanner.sv
// Frame-level bench: a passive keypad matrix model feeds the scanner; a per-frame reference predicts outputs.
module tb_keypad_scanner;
  localparam int DB = 3;

  logic MAX10_CLK1_50 = 1'b0;
  logic rst = 1'b0;
  logic [15:0] keys = 16'h0;

  keypad_scanner_if kif ();

  keypad_scanner #(
    .CLK_HZ(1000), .SCAN_HZ(250), .DEBOUNCE_FRAMES(DB)
  ) dut (
    .MAX10_CLK1_50(MAX10_CLK1_50),
    .rst(rst),
    .kp(kif)
  );

  always #5 MAX10_CLK1_50 = ~MAX10_CLK1_50;

  // Closed switch pulls its column low only while its row is driven low.
  always_comb begin
    for (int c = 0; c < 4; c++) begin
      kif.col_n[c] = 1'b1;
      for (int r = 0; r < 4; r++)
        if (!kif.row_n[r] && keys[r*4+c]) kif.col_n[c] = 1'b0;
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference state: observed outputs plus what the last full frame will make them.
  int         hist[$];
  int         acc;
  logic [8:0] exp_move;
  logic       exp_sel, exp_multi;
  bit         have_pend;
  logic [8:0] pend_move;
  logic       pend_sel, pend_multi, pend_ms, pend_cp;

  task automatic model_reset();
    hist.delete();
    acc       = 0;
    exp_move  = 9'd0;
    exp_sel   = 1'b1;
    exp_multi = 1'b0;
    have_pend = 0;
  endtask

  // Codes: 0 none, 1-9 digits, 10 '*', 11 '#', 12 multi.
  task automatic model_frame(input logic [15:0] k);
    int n, first, code;
    bit accept;
    n = 0;
    first = 0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (!(r == 3 && c == 1) && k[r*4+c]) begin
          if (n == 0) first = (r < 3) ? r*3 + c + 1 : ((c == 0) ? 10 : 11);
          n++;
        end
    code = (n == 0) ? 0 : first;
`ifdef KEYPAD_GHOST_REJECT_EN
    if (n > 1) code = 12;
`endif
    hist.push_back(code);
    if (hist.size() > DB) void'(hist.pop_front());
    accept = (hist.size() == DB) && (code != acc);
    foreach (hist[j]) if (hist[j] != code) accept = 0;

    pend_move  = exp_move;
    pend_sel   = exp_sel;
    pend_multi = (n > 1);
    pend_ms    = 1'b0;
    pend_cp    = 1'b0;
    if (accept) begin
      acc = code;
      pend_sel = 1'b1;
      if (code >= 1 && code <= 9) begin
        pend_move = 9'd1 << (code - 1);
        pend_ms   = 1'b1;
      end else if (code == 10) begin
        pend_move = 9'd0;
        pend_ms   = 1'b1;
      end else if (code == 11) begin
        pend_sel = 1'b0;
        pend_cp  = 1'b1;
      end
    end
    have_pend = 1;
  endtask

  // Called at a negedge just before a frame's first edge; checks every cycle of it.
  task automatic run_frame(input logic [15:0] k, input int ncyc);
    logic ms_now, cp_now;
    logic [3:0] exp_row;
    keys = k;
    for (int i = 0; i < ncyc; i++) begin
      @(posedge MAX10_CLK1_50);
      @(negedge MAX10_CLK1_50);
      ms_now = 1'b0;
      cp_now = 1'b0;
      if (i == 0 && have_pend) begin
        exp_move  = pend_move;
        exp_sel   = pend_sel;
        exp_multi = pend_multi;
        ms_now    = pend_ms;
        cp_now    = pend_cp;
        have_pend = 0;
      end
      exp_row = ~(4'b0001 << (((i + 1) / 4) % 4));
      check("row_n",         32'(kif.row_n),         32'(exp_row));
      check("move",          32'(kif.move),          32'(exp_move));
      check("move_strobe",   32'(kif.move_strobe),   32'(ms_now));
      check("select_n",      32'(kif.select_n),      32'(exp_sel));
      check("confirm_pulse", 32'(kif.confirm_pulse), 32'(cp_now));
      check("multi_key",     32'(kif.multi_key),     32'(exp_multi));
    end
    if (ncyc == 16) model_frame(k);
  endtask

  task automatic hold(input logic [15:0] k, input int frames);
    for (int f = 0; f < frames; f++) run_frame(k, 16);
  endtask

  task automatic do_reset();
    @(negedge MAX10_CLK1_50);
    rst = 1'b0;
    repeat (5) @(posedge MAX10_CLK1_50);
    @(negedge MAX10_CLK1_50);
    check("rst_row_n",    32'(kif.row_n),         32'hE);
    check("rst_move",     32'(kif.move),          32'h0);
    check("rst_strobe",   32'(kif.move_strobe),   32'h0);
    check("rst_select_n", 32'(kif.select_n),      32'h1);
    check("rst_confirm",  32'(kif.confirm_pulse), 32'h0);
    check("rst_multi",    32'(kif.multi_key),     32'h0);
    model_reset();
    rst = 1'b1;
  endtask

  localparam logic [15:0] K1    = 16'h0001;
  localparam logic [15:0] K2    = 16'h0002;
  localparam logic [15:0] K3    = 16'h0004;
  localparam logic [15:0] K5    = 16'h0020;
  localparam logic [15:0] K7    = 16'h0100;
  localparam logic [15:0] K9    = 16'h0400;
  localparam logic [15:0] KSTAR = 16'h1000;
  localparam logic [15:0] KHASH = 16'h4000;

  initial begin
    logic [15:0] k;
    model_reset();
    do_reset();

    hold(16'h0, 2);
    hold(K5, 4);
    hold(16'h0, 3);

    run_frame(K3, 16); run_frame(16'h0, 16);
    run_frame(K3, 16); run_frame(16'h0, 16);
    hold(K3, 3);
    hold(16'h0, 3);

    hold(KHASH, 5);
    hold(16'h0, 4);

    hold(K1, 3);
    hold(KSTAR, 3);
    hold(16'h0, 3);

    hold(K2 | K7, 4);
    hold(16'h0, 3);

    for (int n = 0; n < 30; n++) begin
      case ($urandom_range(0, 5))
        0: k = 16'h0;
        1, 2: begin
          k = 16'h0;
          k[$urandom_range(0, 15)] = 1'b1;
        end
        3: begin
          k = 16'h0;
          k[$urandom_range(0, 15)] = 1'b1;
          k[$urandom_range(0, 15)] = 1'b1;
        end
        4: k = ($urandom_range(0, 1) != 0) ? 16'h2000 : 16'h8888;
        default: k = 16'($urandom);
      endcase
      hold(k, $urandom_range(1, 4));
    end
    hold(16'h0, 3);

    run_frame(K9, 16);
    run_frame(K9, 10);
    do_reset();
    hold(K9, 4);
    hold(16'h0, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Active driver for the 4x4 matrix keypad on the Arduino header.
- Strobes the rows one at a time, samples the columns and debounces whole scan frames.
- Produces the one-hot 9-bit move and the active-low select that the tic-tac-toe game FSM consumes.
- Sits between ARDUINO_IO and the game core, replacing the direct switch/KEY inputs.

Parameters:
- CLK_HZ, 50000000, input clock frequency in Hz.
- SCAN_HZ, 1000, row-step rate in Hz. ROW_CYCLES = CLK_HZ/SCAN_HZ; elaboration error if ROW_CYCLES < 3.
- DEBOUNCE_FRAMES, 4, number of consecutive identical frame codes required to accept a press or a release. Range 1..15.

Ports:
- MAX10_CLK1_50  input  1  system clock
- rst  input  1  reset, synchronous, active-low; clock MAX10_CLK1_50
- col_n  input  4  keypad columns, pulled up, low = key closed in the driven row; asynchronous
- row_n  output  4  keypad row drive, exactly one bit low while scanning
- move  output  9  latched one-hot square selection; bit index = row*3+col
- move_strobe  output  1  one-cycle pulse when move changes
- select_n  output  1  low while '#' is debounced-held; same polarity as KEY[0]
- confirm_pulse  output  1  one-cycle pulse on the debounced '#' press
- multi_key  output  1  high while the last completed frame saw more than one key

Behaviour:
- Reset values (rst low at a clock edge):
  - row_n=4'b1110, move=0, move_strobe=0, select_n=1, confirm_pulse=0, multi_key=0.
  - Row index=0, cycle counter=0, debounce count=0, accepted code=NONE.
  - Synchronizer flops = 4'b1111.
- Reset mid-frame aborts the frame; the partial sample is discarded.
- col_n passes through a 2-flop synchronizer before any use.
- Scan FSM states: DRIVE, SAMPLE.
  - DRIVE: row r is driven low. The counter runs from 0 to ROW_CYCLES-2.
  - SAMPLE: occurs on cycle ROW_CYCLES-1. The synchronized col_n of row r is captured into frame bits [r*4 +: 4]. Then r advances (3 wraps to 0), row_n updates on the next cycle, and the FSM returns to DRIVE.
- Frame = 4 rows = 4*ROW_CYCLES cycles. The frame code is computed on the cycle after row 3 is sampled:
  - NONE: no key closed.
  - DIG1..DIG9: row 0-2, col 0-2.
  - STAR: row 3, col 0.
  - HASH: row 3, col 2.
  - IGNORED: '0' key or column 3; treated as NONE.
  - MULTI: more than one non-ignored key closed.
- Debounce:
  - If the frame code equals the previous frame code, increment the count, saturating at DEBOUNCE_FRAMES; otherwise reset the count to 1.
  - When the count reaches DEBOUNCE_FRAMES and the code differs from the accepted code, the code becomes the accepted code and exactly one accept event fires.
  - A held key therefore produces one event only; there is no auto-repeat.
- Accept actions, all applied on the same clock:
  - DIGk: move <= 1<<(k-1); move_strobe=1 for 1 cycle, even if the value is unchanged.
  - STAR: move <= 0; move_strobe=1.
  - HASH: select_n <= 0; confirm_pulse=1 for 1 cycle. move is not altered.
  - NONE: select_n <= 1.
  - MULTI: multi_key behaviour is defined under Optional Feature.
- Leaving HASH for any accepted code returns select_n to 1.
- multi_key is updated every frame from the raw frame code and is not debounced.

Optional Feature:
- Macro: KEYPAD_GHOST_REJECT_EN.
- Defined: a MULTI frame is treated as its own code.
  - Accepting MULTI changes nothing except releasing select_n to 1.
  - move is held; no strobes fire.
- Undefined: a MULTI frame resolves to the lowest-index closed key, ordered row-major (row 0 col 0 first), before debouncing.
  - multi_key is still asserted.

Test Plan:
- Simulation parameters: CLK_HZ=1000, SCAN_HZ=250 (ROW_CYCLES=4), DEBOUNCE_FRAMES=3.
- Scenarios:
  - Reset: hold rst low for 5 cycles with col_n=4'b1111 -> row_n=4'b1110, move=0, select_n=1. The walk 1110->1101->1011->0111 then repeats every 16 cycles.
  - Press key 5 (row 1, col 1 low while row_n[1]=0) held for 4 frames -> move=9'b000010000 and move_strobe high for exactly 1 cycle at the end of frame 3; no further strobes while held.
  - Bounce: key 3 present in frames 1 and 3, absent in frames 2 and 4, then held for 3 frames -> no event until the 3rd consecutive frame, then move=9'b000000100.
  - Press '#' for 5 frames, then release -> select_n=0 from the accept edge and confirm_pulse pulses once. select_n returns to 1 three frames after release; move is unchanged.
  - After move=9'b000000001, press '*' -> move=0 with one move_strobe.
  - Keys 2 and 7 held together for 4 frames:
    - Compiled with KEYPAD_GHOST_REJECT_EN: multi_key=1 and move is unchanged.
    - Compiled without it: move=9'b000000010 and multi_key=1.
  - Assert rst in the middle of row 2 with key 9 held -> outputs return to reset values; key 9 is re-accepted only after 3 full fresh frames.
